// File: rtl/rfg_ftdi_proto_pkg.sv
// Shared types and constants for the FTDI byte-stream register-file protocol parser.
package rfg_ftdi_proto_pkg;

    typedef enum logic [2:0] {
        ST_HEADER,
        ST_ADDR,
        ST_LEN,
        ST_WR_DATA,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_SEND
    } state_t;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam int LEN_W = 8;
    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // The parser only takes bytes from the FTDI side while no read is outstanding.
    function automatic logic accepts_input(input state_t s);
        return s inside {ST_HEADER, ST_ADDR, ST_LEN, ST_WR_DATA};
    endfunction

endpackage

// File: rtl/rfg_ftdi_byte_protocol.sv
// Parses framed register-file commands from the FTDI byte stream and returns read data.
// Optional: define RFG_PROTO_ADDR_INC_EN to auto-increment the address after each strobe.
module rfg_ftdi_byte_protocol
    import rfg_ftdi_proto_pkg::*;
#(
    parameter int ADDR_W = 8  // 8 or 16
) (
    input  logic              ftdi_clko,
    input  logic              res,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [ADDR_W-1:0] rfg_address,
    output logic              rfg_write,
    output logic [7:0]        rfg_write_value,
    output logic              rfg_read,
    input  logic              rfg_read_valid,
    input  logic [7:0]        rfg_read_value,
    output logic              busy,
    output logic [ERR_W-1:0]  proto_error_count
);

    localparam int         ADDR_BYTES = ADDR_W / 8;
    localparam logic [0:0] ADDR_LAST  = 1'(ADDR_BYTES - 1);

    state_t            state;
    state_t            state_next;
    logic              op_write;
    logic [0:0]        addr_idx;
    logic [LEN_W-1:0]  remaining;
    logic [1:0]        opcode;
    logic              accept;
    logic              m_hs;
    logic [ADDR_W+7:0] addr_shift;

    assign opcode     = s_axis_tdata[7:6];
    assign accept     = s_axis_tvalid && s_axis_tready;
    assign m_hs       = m_axis_tvalid && m_axis_tready;
    assign addr_shift = {rfg_address, s_axis_tdata};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ftdi_clko) begin
        if (res) state <= ST_HEADER;
        else     state <= state_next;
    end

    // NOTE: next_state gets its default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_HEADER:   if (accept && (opcode == OP_WRITE || opcode == OP_READ)) state_next = ST_ADDR;
            ST_ADDR:     if (accept && addr_idx == ADDR_LAST) state_next = ST_LEN;
            ST_LEN:      if (accept) state_next = op_write ? ST_WR_DATA : ST_RD_ISSUE;
            ST_WR_DATA:  if (accept && remaining == '0) state_next = ST_HEADER;
            ST_RD_ISSUE: state_next = ST_RD_WAIT;
            ST_RD_WAIT:  if (rfg_read_valid) state_next = ST_RD_SEND;
            ST_RD_SEND:  if (m_hs) state_next = (remaining == '0) ? ST_HEADER : ST_RD_ISSUE;
            default:     state_next = ST_HEADER;
        endcase
    end

    // Outputs are registered from state_next so they line up with the state they describe.
    always_ff @(posedge ftdi_clko) begin
        if (res) begin
            s_axis_tready     <= 1'b0;
            m_axis_tdata      <= '0;
            m_axis_tvalid     <= 1'b0;
            rfg_address       <= '0;
            rfg_write         <= 1'b0;
            rfg_write_value   <= '0;
            rfg_read          <= 1'b0;
            busy              <= 1'b0;
            proto_error_count <= '0;
            op_write          <= 1'b0;
            addr_idx          <= '0;
            remaining         <= '0;
        end else begin
            s_axis_tready <= accepts_input(state_next);
            busy          <= (state_next != ST_HEADER);
            rfg_read      <= (state_next == ST_RD_ISSUE);
            rfg_write     <= 1'b0;

`ifdef RFG_PROTO_ADDR_INC_EN
            if (rfg_write || rfg_read) rfg_address <= rfg_address + 1'b1;
`endif

            if (accept) begin
                unique case (state)
                    ST_HEADER: begin
                        if (opcode == OP_WRITE || opcode == OP_READ) begin
                            op_write <= (opcode == OP_WRITE);
                            addr_idx <= '0;
                        end else if (opcode == OP_ILLEGAL && proto_error_count != ERR_MAX) begin
                            proto_error_count <= proto_error_count + 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        rfg_address <= addr_shift[ADDR_W-1:0];
                        addr_idx    <= addr_idx + 1'b1;
                    end
                    ST_LEN: remaining <= s_axis_tdata;
                    ST_WR_DATA: begin
                        rfg_write       <= 1'b1;
                        rfg_write_value <= s_axis_tdata;
                        if (remaining != '0) remaining <= remaining - 1'b1;
                    end
                    default: ;
                endcase
            end

            if (state == ST_RD_WAIT && rfg_read_valid) begin
                m_axis_tdata  <= rfg_read_value;
                m_axis_tvalid <= 1'b1;
            end else if (m_hs) begin
                m_axis_tvalid <= 1'b0;
                if (remaining != '0) remaining <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rfg_ftdi_byte_protocol.sv
// Self-checking bench for rfg_ftdi_byte_protocol (8-bit and 16-bit address instances).
module tb_rfg_ftdi_byte_protocol;

`ifdef RFG_PROTO_ADDR_INC_EN
    localparam int INC = 1;
`else
    localparam int INC = 0;
`endif

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct packed {
        logic [7:0] hdr;
        logic       exp_busy;
        logic [7:0] exp_err;
    } hdr_vec_t;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       sel16;
    logic       s_tvalid8, s_tvalid16, s_tready8, s_tready16, s_tready_sel;

    logic [7:0]  m_tdata8, wv8, rvd8, err8;
    logic        m_tvalid8, m_ready8, wr8, rd8, rv8, busy8;
    logic [7:0]  addr8;
    logic [7:0]  m_tdata16, wv16, rvd16, err16;
    logic        m_tvalid16, m_ready16, wr16, rd16, rv16, busy16;
    logic [15:0] addr16;

    assign s_tvalid8    = s_tvalid & ~sel16;
    assign s_tvalid16   = s_tvalid & sel16;
    assign s_tready_sel = sel16 ? s_tready16 : s_tready8;

    rfg_ftdi_byte_protocol #(.ADDR_W(8)) dut (
        .ftdi_clko(clk), .res(res),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid8), .s_axis_tready(s_tready8),
        .m_axis_tdata(m_tdata8), .m_axis_tvalid(m_tvalid8), .m_axis_tready(m_ready8),
        .rfg_address(addr8), .rfg_write(wr8), .rfg_write_value(wv8),
        .rfg_read(rd8), .rfg_read_valid(rv8), .rfg_read_value(rvd8),
        .busy(busy8), .proto_error_count(err8)
    );

    rfg_ftdi_byte_protocol #(.ADDR_W(16)) dut16 (
        .ftdi_clko(clk), .res(res),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid16), .s_axis_tready(s_tready16),
        .m_axis_tdata(m_tdata16), .m_axis_tvalid(m_tvalid16), .m_axis_tready(m_ready16),
        .rfg_address(addr16), .rfg_write(wr16), .rfg_write_value(wv16),
        .rfg_read(rd16), .rfg_read_valid(rv16), .rfg_read_value(rvd16),
        .busy(busy16), .proto_error_count(err16)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    wr_t         exp_wr[$];
    logic [15:0] exp_ra8[$];
    logic [7:0]  exp_m8[$];
    logic [7:0]  rd_data8[$];
    int          wr_cyc[$];
    int          rd_lat8 = 2;
    int          rd16_n = 0;
    int          m16_n  = 0;
    int          resp16 = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves s_tvalid high so consecutive calls stream back-to-back.
    task automatic send_byte(input logic [7:0] b);
        bit hs = 1'b0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        for (int k = 0; k < 200 && !hs; k++) begin
            @(negedge clk);
            hs = s_tready_sel;
            @(posedge clk);
            #1;
        end
        if (!hs) check("s_axis handshake timeout", 32'(hs), 32'd1);
    endtask

    task automatic send_frame(input byte_q_t f);
        foreach (f[i]) send_byte(f[i]);
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input int max, input string name);
        for (int i = 0; i < max; i++) begin
            if (exp_wr.size() == 0 && exp_m8.size() == 0 && exp_ra8.size() == 0) break;
            cycles(1);
        end
        check(name, 32'(exp_wr.size() + exp_m8.size() + exp_ra8.size()), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard for the 8-bit instance.
    initial forever begin
        wr_t e;
        @(negedge clk);
        if (wr8) begin
            wr_cyc.push_back(cyc);
            if (exp_wr.size() == 0) check("unexpected rfg_write", 32'(wr8), 32'd0);
            else begin
                e = exp_wr.pop_front();
                check("rfg_address on write", 32'(addr8), 32'(e.addr));
                check("rfg_write_value", 32'(wv8), 32'(e.data));
            end
        end
        if (rd8) begin
            if (exp_ra8.size() == 0) check("unexpected rfg_read", 32'(rd8), 32'd0);
            else check("rfg_address on read", 32'(addr8), 32'(exp_ra8.pop_front()));
        end
        if (m_tvalid8) begin
            if (exp_m8.size() == 0) check("unexpected m_axis byte", 32'(m_tvalid8), 32'd0);
            else begin
                check("m_axis_tdata", 32'(m_tdata8), 32'(exp_m8[0]));
                if (m_ready8) void'(exp_m8.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] v;
        rv8  = 1'b0;
        rvd8 = 8'h00;
        forever begin
            @(negedge clk);
            if (rd8) begin
                v = (rd_data8.size() != 0) ? rd_data8.pop_front() : 8'hEE;
                repeat (rd_lat8) @(posedge clk);
                #1 rv8 = 1'b1;
                rvd8 = v;
                @(posedge clk);
                #1 rv8 = 1'b0;
            end
        end
    end

    // Scoreboard and one-cycle-latency register file for the 16-bit instance.
    initial forever begin
        @(negedge clk);
        if (rd16) begin
            check("dut16 read address", 32'(addr16), 32'(16'h0100 + 16'(INC * rd16_n)));
            rd16_n++;
        end
        if (m_tvalid16 && m_ready16) begin
            check("dut16 m_axis_tdata", 32'(m_tdata16), 32'(m16_n[7:0] ^ 8'h3C));
            m16_n++;
        end
        if (wr16) check("dut16 unexpected write", 32'({wr16, wv16}), 32'd0);
    end

    initial begin
        rv16  = 1'b0;
        rvd16 = 8'h00;
        forever begin
            @(negedge clk);
            if (rd16) begin
                @(posedge clk);
                #1 rv16 = 1'b1;
                rvd16 = resp16[7:0] ^ 8'h3C;
                resp16++;
                @(posedge clk);
                #1 rv16 = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hdr_vec_t tbl[5];
        byte_q_t  f;
        bit       tready_seen;

        tbl[0] = '{8'h00, 1'b0, 8'd0};
        tbl[1] = '{8'hC0, 1'b0, 8'd1};
        tbl[2] = '{8'hFF, 1'b0, 8'd2};
        tbl[3] = '{8'h3F, 1'b0, 8'd2};
        tbl[4] = '{8'h7F, 1'b1, 8'd2};

        res = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; sel16 = 1'b0;
        m_ready8 = 1'b1; m_ready16 = 1'b1;
        cycles(3);

        @(negedge clk);
        check("reset s_axis_tready", 32'(s_tready8), 32'd0);
        check("reset m_axis_tvalid", 32'(m_tvalid8), 32'd0);
        check("reset m_axis_tdata", 32'(m_tdata8), 32'd0);
        check("reset rfg_write", 32'(wr8), 32'd0);
        check("reset rfg_read", 32'(rd8), 32'd0);
        check("reset rfg_address", 32'(addr8), 32'd0);
        check("reset rfg_write_value", 32'(wv8), 32'd0);
        check("reset busy", 32'(busy8), 32'd0);
        check("reset proto_error_count", 32'(err8), 32'd0);
        check("reset dut16 rfg_address", 32'(addr16), 32'd0);
        @(posedge clk);
        #1 res = 1'b0;
        cycles(2);
        check("s_axis_tready after reset", 32'(s_tready8), 32'd1);

        // Header decode table: NOP / illegal / write-with-junk-low-bits.
        for (int i = 0; i < 5; i++) begin
            send_byte(tbl[i].hdr);
            s_tvalid = 1'b0;
            cycles(2);
            check($sformatf("hdr %02h busy", tbl[i].hdr), 32'(busy8), 32'(tbl[i].exp_busy));
            check($sformatf("hdr %02h error count", tbl[i].hdr), 32'(err8), 32'(tbl[i].exp_err));
        end
        exp_wr.push_back('{16'h0034, 8'h5C});
        f = '{8'h34, 8'h00, 8'h5C};
        send_frame(f);
        wait_drain(50, "write after NOP/illegal drain");
        check("error count after write", 32'(err8), 32'd2);

        // Single write, fixed address.
        exp_wr.push_back('{16'h0012, 8'hA5});
        f = '{8'h40, 8'h12, 8'h00, 8'hA5};
        send_frame(f);
        wait_drain(50, "single write drain");
        cycles(1);
        check("busy after single write", 32'(busy8), 32'd0);
        check("s_axis_tready after single write", 32'(s_tready8), 32'd1);

        // Back-to-back write burst.
        wr_cyc.delete();
        for (int i = 0; i < 3; i++) exp_wr.push_back('{16'(8'h10 + INC * i), 8'(i + 1)});
        f = '{8'h40, 8'h10, 8'h02, 8'h01, 8'h02, 8'h03};
        send_frame(f);
        wait_drain(50, "write burst drain");
        check("write burst strobe count", 32'(wr_cyc.size()), 32'd3);
        if (wr_cyc.size() == 3) check("write burst consecutive", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);

        // Read burst with stalled sink; a pending NOP byte must stay unconsumed.
        m_ready8 = 1'b0;
        rd_lat8  = 2;
        rd_data8 = '{8'h5A, 8'hC3};
        exp_ra8.push_back(16'h0020);
        exp_ra8.push_back(16'(8'h20 + INC));
        exp_m8.push_back(8'h5A);
        exp_m8.push_back(8'hC3);
        f = '{8'h80, 8'h20, 8'h01};
        send_frame(f);
        s_tdata = 8'h00; s_tvalid = 1'b1;
        tready_seen = 1'b0;
        for (int k = 0; k < 100 && !m_tvalid8; k++) begin
            tready_seen |= s_tready8;
            cycles(1);
        end
        check("m_axis_tvalid rises", 32'(m_tvalid8), 32'd1);
        repeat (5) begin
            tready_seen |= s_tready8;
            cycles(1);
        end
        m_ready8 = 1'b1;
        for (int k = 0; k < 100 && exp_m8.size() != 0; k++) begin
            tready_seen |= s_tready8;
            cycles(1);
        end
        check("s_axis_tready low during read", 32'(tready_seen), 32'd0);
        wait_drain(50, "read burst drain");
        cycles(1);
        check("m_axis_tvalid drops after last byte", 32'(m_tvalid8), 32'd0);
        s_tvalid = 1'b0;
        cycles(2);

        // Reset after the 2nd of 4 write data bytes.
        exp_wr.push_back('{16'h0030, 8'h11});
        exp_wr.push_back('{16'(8'h30 + INC), 8'h22});
        f = '{8'h40, 8'h30, 8'h03, 8'h11, 8'h22};
        send_frame(f);
        res = 1'b1;
        cycles(2);
        res = 1'b0;
        cycles(3);
        check("writes pending after reset", 32'(exp_wr.size()), 32'd0);
        check("rfg_address after mid-frame reset", 32'(addr8), 32'd0);
        check("error count cleared by reset", 32'(err8), 32'd0);
        rd_data8 = '{8'h77};
        exp_ra8.push_back(16'h0005);
        exp_m8.push_back(8'h77);
        f = '{8'h80, 8'h05, 8'h00};
        send_frame(f);
        wait_drain(100, "read after reset drain");
        cycles(2);
        check("busy after read", 32'(busy8), 32'd0);

        // Reset while a read-back byte is stalled: the byte is dropped.
        m_ready8 = 1'b0;
        rd_data8 = '{8'h99};
        exp_ra8.push_back(16'h0006);
        exp_m8.push_back(8'h99);
        f = '{8'h80, 8'h06, 8'h00};
        send_frame(f);
        for (int k = 0; k < 100 && !m_tvalid8; k++) cycles(1);
        check("stalled m_axis_tvalid", 32'(m_tvalid8), 32'd1);
        res = 1'b1;
        cycles(1);
        check("m_axis_tvalid dropped by reset", 32'(m_tvalid8), 32'd0);
        exp_m8.delete();
        res = 1'b0;
        m_ready8 = 1'b1;
        cycles(5);
        check("m_axis_tvalid stays low", 32'(m_tvalid8), 32'd0);
        check("busy after reset", 32'(busy8), 32'd0);

        // Error counter saturation.
        for (int i = 0; i < 258; i++) send_byte(8'hC0);
        s_tvalid = 1'b0;
        cycles(2);
        check("error count saturates", 32'(err8), 32'd255);
        check("busy after illegal stream", 32'(busy8), 32'd0);

        // 16-bit address, 256-transfer read.
        sel16 = 1'b1;
        f = '{8'h80, 8'h01, 8'h00, 8'hFF};
        send_frame(f);
        for (int k = 0; k < 4000 && m16_n < 256; k++) cycles(1);
        cycles(5);
        check("dut16 read strobe count", 32'(rd16_n), 32'd256);
        check("dut16 m_axis byte count", 32'(m16_n), 32'd256);
        check("dut16 busy after frame", 32'(busy16), 32'd0);
        check("dut16 error count", 32'(err16), 32'd0);
        check("dut16 s_axis_tready after frame", 32'(s_tready16), 32'd1);
        sel16 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rfg_ftdi_byte_protocol.md
Name: rfg_ftdi_byte_protocol

Overview:
- Downstream stage of the FTDI synchronous-FIFO AXIS bridge, in the `ftdi_clko` domain.
- Consumes the byte stream read from the FTDI chip (slave AXIS) and parses framed register-file commands.
- Drives single-cycle register-file read/write strobes.
- Returns read data as a byte stream (master AXIS) to the bridge's FTDI write side.

Parameters:
- ADDR_W, 8, register address width; must be 8 or 16. Address bytes per frame = ADDR_W/8, MSB first.

Ports:
- ftdi_clko  in  1  sole clock.
- res  in  1  synchronous reset, active-high.
- s_axis_tdata  in  8  command/data byte from FTDI.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  parser accepts byte.
- m_axis_tdata  out  8  read-back byte to FTDI.
- m_axis_tvalid  out  1  read-back byte valid.
- m_axis_tready  in  1  FTDI write side accepts.
- rfg_address  out  ADDR_W  register address.
- rfg_write  out  1  one-cycle write strobe.
- rfg_write_value  out  8  write data, valid with rfg_write.
- rfg_read  out  1  one-cycle read strobe.
- rfg_read_valid  in  1  read data valid, ≥1 cycle after rfg_read.
- rfg_read_value  in  8  read data.
- busy  out  1  high in any state except HEADER.
- proto_error_count  out  8  saturating count of illegal header bytes.

Behaviour:
- Frame format: HEADER, ADDR (ADDR_W/8 bytes), LEN (transfer count = LEN+1, i.e. 1..256), then LEN+1 data bytes for a write or none for a read.
- HEADER[7:6] opcode: 2'b01 write, 2'b10 read, 2'b00 NOP (byte consumed, ignored), 2'b11 illegal (byte consumed, proto_error_count increments, saturating at 255). HEADER[5:0] ignored.
- All outputs are registered. Reset values:
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0
  - rfg_write=0, rfg_read=0, rfg_address=0, rfg_write_value=0
  - busy=0, proto_error_count=0
  - state=HEADER, counters=0.
- States: HEADER, ADDR, LEN, WR_DATA, RD_ISSUE, RD_WAIT, RD_SEND.
- s_axis_tready is 1 in HEADER, ADDR, LEN and WR_DATA; 0 in the RD_* states. A byte is consumed only on tvalid&&tready.
- HEADER:
  - write → ADDR with op=W; read → ADDR with op=R.
  - NOP or illegal → stay in HEADER.
- ADDR: shift bytes into rfg_address MSB first. After the last address byte → LEN.
- LEN: latch remaining=LEN. Next state: op=W → WR_DATA; op=R → RD_ISSUE.
- WR_DATA:
  - Each accepted byte produces rfg_write=1 for exactly the following cycle, with rfg_write_value = that byte.
  - Sustains one write per cycle under back-to-back tvalid.
  - After the byte with remaining==0 → HEADER; otherwise remaining decrements.
- RD_ISSUE: rfg_read=1 for one cycle → RD_WAIT.
- RD_WAIT: on rfg_read_valid, latch rfg_read_value into m_axis_tdata, set m_axis_tvalid=1 → RD_SEND. rfg_read_valid outside RD_WAIT is ignored.
- RD_SEND:
  - Hold tdata/tvalid stable until m_axis_tready.
  - On handshake, tvalid drops next cycle.
  - remaining==0 → HEADER; else decrement → RD_ISSUE.
  - Throughput is at most one read byte per 3 cycles; acceptable.
- No input is accepted while a read is outstanding, so the FTDI read path back-pressures naturally.
- Reset mid-frame: abort immediately. Any pending strobe is cancelled, and any m_axis byte not yet transferred is dropped. The next byte is parsed as HEADER.
- LEN=0xFF gives 256 transfers; the remaining counter is 8-bit and must not wrap early.

Optional Feature:
- Macro: RFG_PROTO_ADDR_INC_EN.
- Defined: rfg_address increments by 1 after each rfg_write/rfg_read strobe within a frame, wrapping modulo 2^ADDR_W.
- Undefined: rfg_address is fixed for the frame (FIFO-style register burst).

Decomposition:
- Package rfg_ftdi_proto_pkg holds:
  - state enum
  - opcode localparams (OP_NOP=2'b00, OP_WRITE=2'b01, OP_READ=2'b10, OP_ILLEGAL=2'b11)
  - LEN_W=8 and the error counter width.
- No sub-module; a single FSM plus datapath.

Test Plan:
- Write, fixed address. Bytes 0x40,0x12,0x00,0xA5 → one rfg_write with address 0x12, value 0xA5; busy falls and the next byte is taken as HEADER.
- Write burst with address increment (ADDR_INC_EN defined). Bytes 0x40,0x10,0x02,0x01,0x02,0x03 → writes (0x10,0x01),(0x11,0x02),(0x12,0x03) on consecutive cycles.
- Read burst with stalling sink. Bytes 0x80,0x20,0x01; rfg returns 0x5A then 0xC3 with 2-cycle latency; m_axis_tready held low 5 cycles → m_axis emits 0x5A,0xC3 in order, data stable while stalled, s_axis_tready=0 throughout.
- NOP and illegal headers. Bytes 0x00,0xC0,0xFF, then a valid write frame → proto_error_count=2, no strobes for the first three bytes, and the write executes correctly.
- Reset mid-burst. Assert res after the 2nd of 4 write data bytes → no further rfg_write; the next bytes 0x80,0x05,0x00 perform a single read of address 0x05.
- ADDR_W=16, 256-transfer read. Bytes 0x80,0x01,0x00,0xFF → exactly 256 rfg_read strobes; address 0x0100, or 0x0100..0x01FF with ADDR_INC_EN defined.
